// File: rtl/vecmat_engine.sv
// Signed fixed-point vector x matrix engine: y[c] = sum_r x[r]*W[r][c], rounded and saturated to 16 bits.
// Optional ReLU on results when VECMAT_RELU_EN is defined; states READY|CLEAR|MAC|OUT|DONE.
module vecmat_engine #(
  parameter int ROW_BITS  = 4,
  parameter int COL_BITS  = 4,
  parameter int FRAC_BITS = 12,
  parameter int ACC_W     = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ROW_BITS-1:0] rows_m1_i,
  input  logic [COL_BITS-1:0] cols_m1_i,
  input  logic [15:0]         data1_i,
  input  logic [15:0]         data2_i,
  output logic [ROW_BITS-1:0] sel_row_o,
  output logic [COL_BITS-1:0] sel_col_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                out_valid_o,
  output logic [15:0]         out_data_o,
  output logic [COL_BITS-1:0] out_col_o
);

  typedef enum logic [2:0] {S_READY, S_CLEAR, S_MAC, S_OUT, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'sd1 << (FRAC_BITS - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -(ACC_W'(32768));

  state_t                    state_q, state_d;
  logic [ROW_BITS-1:0]       rows_q, rows_d, row_cnt_q, row_cnt_d, sel_row_q, sel_row_d;
  logic [COL_BITS-1:0]       cols_q, cols_d, col_q, col_d, sel_col_q, sel_col_d;
  logic [COL_BITS-1:0]       out_col_q, out_col_d;
  logic [15:0]               out_data_q, out_data_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   mac_sum, rnd, shr;
  logic [15:0]               sat_res, fmt_res;
  logic                      load_out;

  // Result formatting works on the sum being written by the final MAC edge,
  // so out_data is already registered when OUT is entered.
  always_comb begin
    prod    = $signed(data1_i) * $signed(data2_i);
    mac_sum = acc_q + {{(ACC_W-32){prod[31]}}, prod};
    rnd     = mac_sum + RND_HALF;
    shr     = rnd >>> FRAC_BITS;
    if (shr > SAT_MAX)      sat_res = 16'h7FFF;
    else if (shr < SAT_MIN) sat_res = 16'h8000;
    else                    sat_res = shr[15:0];
`ifdef VECMAT_RELU_EN
    fmt_res = sat_res[15] ? 16'h0000 : sat_res;
`else
    fmt_res = sat_res;
`endif
  end

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_cnt_d  = row_cnt_q;
    col_d      = col_q;
    sel_row_d  = sel_row_q;
    sel_col_d  = sel_col_q;
    acc_d      = acc_q;
    load_out   = 1'b0;
    case (state_q)
      S_READY: begin
        if (start_i) begin
          rows_d    = rows_m1_i;
          cols_d    = cols_m1_i;
          col_d     = '0;
          sel_row_d = '0;
          sel_col_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_d     = '0;
        row_cnt_d = '0;
        sel_row_d = (sel_row_q == rows_q) ? sel_row_q : sel_row_q + ROW_BITS'(1);
        state_d   = S_MAC;
      end
      S_MAC: begin
        acc_d     = mac_sum;
        sel_row_d = (sel_row_q == rows_q) ? sel_row_q : sel_row_q + ROW_BITS'(1);
        if (row_cnt_q == rows_q) begin
          load_out = 1'b1;
          state_d  = S_OUT;
        end else begin
          row_cnt_d = row_cnt_q + ROW_BITS'(1);
        end
      end
      S_OUT: begin
        if (col_q != cols_q) begin
          col_d     = col_q + COL_BITS'(1);
          sel_row_d = '0;
          sel_col_d = col_q + COL_BITS'(1);
          state_d   = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_READY;
      default: state_d = S_READY;
    endcase
    if (abort_i) begin
      state_d  = S_READY;
      acc_d    = '0;
      load_out = 1'b0;
    end
  end

  assign out_data_d = load_out ? fmt_res : out_data_q;
  assign out_col_d  = load_out ? col_q : out_col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_READY;
      rows_q     <= '0;
      cols_q     <= '0;
      row_cnt_q  <= '0;
      col_q      <= '0;
      sel_row_q  <= '0;
      sel_col_q  <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_cnt_q  <= row_cnt_d;
      col_q      <= col_d;
      sel_row_q  <= sel_row_d;
      sel_col_q  <= sel_col_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_col_q  <= out_col_d;
    end
  end

  assign sel_row_o   = sel_row_q;
  assign sel_col_o   = sel_col_q;
  assign ready_o     = (state_q == S_READY);
  assign busy_o      = (state_q == S_CLEAR) || (state_q == S_MAC) || (state_q == S_OUT);
  assign done_o      = (state_q == S_DONE);
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = out_data_q;
  assign out_col_o   = out_col_q;

endmodule

// File: tb/tb_vecmat_engine.sv
// Bench for vecmat_engine: registered tensor-storage model, expected-result queue and observed-result queue.
module tb_vecmat_engine;
  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [3:0]  rows_m1, cols_m1, sel_row, sel_col, out_col;
  logic [15:0] data1, data2, out_data;
  logic        ready, busy, done, out_valid;

  logic [15:0] xmem [16];
  logic [15:0] wmem [16][16];

  typedef struct { logic [15:0] data; logic [3:0] col; } exp_t;
  typedef struct { logic [15:0] data; logic [3:0] col; int cyc; } obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  vecmat_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .rows_m1_i(rows_m1), .cols_m1_i(cols_m1), .data1_i(data1), .data2_i(data2),
    .sel_row_o(sel_row), .sel_col_o(sel_col), .ready_o(ready), .busy_o(busy),
    .done_o(done), .out_valid_o(out_valid), .out_data_o(out_data), .out_col_o(out_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data1 <= xmem[sel_row];
    data2 <= wmem[sel_row][sel_col];
  end

`ifdef VECMAT_RELU_EN
  localparam logic [15:0] NEG_ONE_RES = 16'h0000;
`else
  localparam logic [15:0] NEG_ONE_RES = 16'hF000;
`endif

  function automatic logic [15:0] model(input int r, input int c);
    longint acc = 0;
    for (int i = 0; i <= r; i++)
      acc += longint'($signed(xmem[i])) * longint'($signed(wmem[i][c]));
    acc = (acc + 2048) >>> 12;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef VECMAT_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[15:0];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      xmem[i] = 16'h0;
      for (int j = 0; j < 16; j++) wmem[i][j] = 16'h0;
    end
  endtask

  // Starts one operation and records strobes; cycle k is the k-th cycle after the start edge.
  task automatic run_op(input int r, input int c, input int abort_at, input int restart_at,
                        output int done_cyc, output int ready_cyc);
    done_cyc = -1;
    ready_cyc = -1;
    @(negedge clk);
    rows_m1 = r[3:0];
    cols_m1 = c[3:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rows_m1 = ~rows_m1;
    cols_m1 = ~cols_m1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (out_valid) obs_q.push_back('{out_data, out_col, cyc});
      if (done && done_cyc < 0) done_cyc = cyc;
      if (ready) begin
        ready_cyc = cyc;
        break;
      end
      abort = (cyc == abort_at);
      start = (cyc == restart_at);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (ready !== 1'b1)      begin n_miss++; $display("FAIL reset_ready got %b want 1", ready); end
    n_vec++; if (busy !== 1'b0)       begin n_miss++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)       begin n_miss++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (out_valid !== 1'b0)  begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 16'h0)  begin n_miss++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_vec++; if (out_col !== 4'h0)    begin n_miss++; $display("FAIL reset_out_col got %h want 0", out_col); end
    n_vec++; if (sel_row !== 4'h0)    begin n_miss++; $display("FAIL reset_sel_row got %h want 0", sel_row); end
    n_vec++; if (sel_col !== 4'h0)    begin n_miss++; $display("FAIL reset_sel_col got %h want 0", sel_col); end
  endtask

  task automatic test_basic();
    int dc, rc;
    exp_t e;
    obs_t o;
    clear_mem();
    xmem[0] = 16'h1000; xmem[1] = 16'h2000;
    wmem[0][0] = 16'h1000; wmem[1][0] = 16'h1000;
    exp_q.push_back('{16'h3000, 4'd0});
    run_op(1, 0, 0, 0, dc, rc);
    n_vec++; if (dc != 5) begin n_miss++; $display("FAIL basic_done_cycle got %0d want 5", dc); end
    n_vec++; if (rc != 6) begin n_miss++; $display("FAIL basic_ready_cycle got %0d want 6", rc); end
    n_vec++;
    if (obs_q.size() != 1) begin
      n_miss++; $display("FAIL basic_count got %0d want 1", obs_q.size());
    end else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++; if (o.data !== e.data) begin n_miss++; $display("FAIL basic_data got %h want %h", o.data, e.data); end
      n_vec++; if (o.col !== e.col)   begin n_miss++; $display("FAIL basic_col got %0d want %0d", o.col, e.col); end
      n_vec++; if (o.cyc != 4)        begin n_miss++; $display("FAIL basic_valid_cycle got %0d want 4", o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_multi_col();
    int dc, rc, prev;
    exp_t e;
    obs_t o;
    clear_mem();
    xmem[0] = 16'h1000;
    wmem[0][0] = 16'h1000; wmem[0][1] = 16'hF000; wmem[0][2] = 16'h0800;
    exp_q.push_back('{16'h1000, 4'd0});
    exp_q.push_back('{NEG_ONE_RES, 4'd1});
    exp_q.push_back('{16'h0800, 4'd2});
    run_op(0, 2, 0, 0, dc, rc);
    n_vec++; if (dc != 10) begin n_miss++; $display("FAIL multi_done_cycle got %0d want 10", dc); end
    prev = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_miss++; $display("FAIL multi_missing col %0d want %h", e.col, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data || o.col !== e.col || o.cyc != prev + 3) begin
          n_miss++;
          $display("FAIL multi_result got %h col %0d cyc %0d want %h col %0d cyc %0d",
                   o.data, o.col, o.cyc, e.data, e.col, prev + 3);
        end
        prev = o.cyc;
      end
    end
    n_vec++; if (obs_q.size() != 0) begin n_miss++; $display("FAIL multi_extra got %0d want 0", obs_q.size()); end
    n_vec++; if (out_data !== 16'h0800) begin n_miss++; $display("FAIL multi_hold got %h want 0800", out_data); end
    obs_q.delete();
  endtask

  task automatic test_saturation();
    int dc, rc;
    logic [15:0] xv [3] = '{16'h7FFF, 16'h7FFF, 16'h0001};
    logic [15:0] wv [3] = '{16'h7FFF, 16'h8000, 16'h0800};
    int          rm [3] = '{3, 3, 0};
    logic [15:0] ev [3] = '{16'h7FFF, 16'h8000, 16'h0001};
    exp_t e;
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      clear_mem();
      for (int i = 0; i <= rm[k]; i++) begin xmem[i] = xv[k]; wmem[i][0] = wv[k]; end
`ifdef VECMAT_RELU_EN
      exp_q.push_back('{(ev[k][15] ? 16'h0000 : ev[k]), 4'd0});
`else
      exp_q.push_back('{ev[k], 4'd0});
`endif
      run_op(rm[k], 0, 0, 0, dc, rc);
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() != 1) begin
        n_miss++; $display("FAIL sat%0d_count got %0d want 1", k, obs_q.size());
      end else begin
        o = obs_q.pop_front();
        if (o.data !== e.data) begin n_miss++; $display("FAIL sat%0d_data got %h want %h", k, o.data, e.data); end
      end
      obs_q.delete();
    end
  endtask

  task automatic test_abort_and_start();
    int dc, rc;
    exp_t e;
    obs_t o;
    clear_mem();
    for (int i = 0; i < 4; i++) begin xmem[i] = 16'h1000; wmem[i][0] = 16'h1000; wmem[i][1] = 16'h2000; end
    run_op(3, 1, 3, 0, dc, rc);
    n_vec++; if (rc != 4)            begin n_miss++; $display("FAIL abort_ready_cycle got %0d want 4", rc); end
    n_vec++; if (dc != -1)           begin n_miss++; $display("FAIL abort_done got cycle %0d want none", dc); end
    n_vec++; if (obs_q.size() != 0)  begin n_miss++; $display("FAIL abort_valid got %0d strobes want 0", obs_q.size()); end
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; rows_m1 = 4'd0; cols_m1 = 4'd0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_vec++; if (ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++; $display("FAIL start_abort_ready got ready %b busy %b want 1 0", ready, busy);
    end
    exp_q.push_back('{16'h4000, 4'd0});
    exp_q.push_back('{16'h7FFF, 4'd1});
    run_op(3, 1, 0, 2, dc, rc);
    n_vec++; if (dc != 13) begin n_miss++; $display("FAIL restart_done_cycle got %0d want 13", dc); end
    n_vec++; if (obs_q.size() != 2) begin n_miss++; $display("FAIL restart_count got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o.data !== e.data || o.col !== e.col) begin
        n_miss++; $display("FAIL restart_result got %h col %0d want %h col %0d", o.data, o.col, e.data, e.col);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int dc, rc;
    bit seen = 1'b0;
    exp_t e;
    obs_t o;
    clear_mem();
    xmem[0] = 16'h1000; xmem[1] = 16'h2000;
    wmem[0][0] = 16'h1000; wmem[1][0] = 16'h1000;
    @(negedge clk);
    rows_m1 = 4'd1; cols_m1 = 4'd0; start = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      seen = out_valid;
    end
    n_vec++;
    if (!seen) begin
      n_miss++; $display("FAIL rstmid_no_out got 0 want 1");
    end else begin
      rst_n = 1'b0;
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || out_data !== 16'h0) begin
        n_miss++;
        $display("FAIL rstmid_outputs got v%b b%b r%b d%b %h want v0 b0 r1 d0 0000",
                 out_valid, busy, ready, done, out_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{16'h3000, 4'd0});
    run_op(1, 0, 0, 0, dc, rc);
    e = exp_q.pop_front();
    n_vec++;
    if (obs_q.size() != 1 || dc != 5) begin
      n_miss++; $display("FAIL rstmid_rerun got %0d strobes done %0d want 1 strobe done 5", obs_q.size(), dc);
    end else begin
      o = obs_q.pop_front();
      n_vec++; if (o.data !== e.data) begin n_miss++; $display("FAIL rstmid_data got %h want %h", o.data, e.data); end
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int dc, rc, r, c;
    exp_t e;
    obs_t o;
    for (int k = 0; k < 3; k++) begin
      r = $urandom_range(0, 15);
      c = $urandom_range(0, 4);
      for (int i = 0; i < 16; i++) begin
        xmem[i] = 16'($urandom);
        for (int j = 0; j < 16; j++) wmem[i][j] = (k == 0) ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom);
      end
      for (int j = 0; j <= c; j++) exp_q.push_back('{model(r, j), 4'(j)});
      run_op(r, c, 0, 0, dc, rc);
      n_vec++;
      if (dc != (c + 1) * (r + 3) + 1) begin
        n_miss++; $display("FAIL b2b%0d_done_cycle got %0d want %0d", k, dc, (c + 1) * (r + 3) + 1);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs_q.size() == 0) begin
          n_miss++; $display("FAIL b2b%0d_missing col %0d want %h", k, e.col, e.data);
        end else begin
          o = obs_q.pop_front();
          if (o.data !== e.data || o.col !== e.col) begin
            n_miss++; $display("FAIL b2b%0d_result got %h col %0d want %h col %0d", k, o.data, o.col, e.data, e.col);
          end
        end
      end
      obs_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rows_m1 = 4'd0; cols_m1 = 4'd0;
    clear_mem();
    #22;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_multi_col();
    test_saturation();
    test_abort_and_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
